// File: rtl/usb_rx_bit_timer.sv
// USB full-speed RX bit timer: oversampled bit clock recovery, payload
// bit/byte framing and bit-stuff detection for the receive shift register.
module usb_rx_bit_timer #(
   parameter int CLKS_PER_BIT  = 8,
   parameter int SAMPLE_PHASE  = 2,
   parameter int BITS_PER_BYTE = 8,
   parameter int STUFF_EN      = 1,
   parameter int MAX_RUN       = 6,
   parameter int BYTE_CNT_W    = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             rcving,
   input  logic                             d_edge,
   input  logic                             d_orig,
   output logic                             shift_enable,
   output logic                             stuff_skip,
   output logic                             byte_received,
   output logic                             stuff_err,
   output logic [$clog2(BITS_PER_BYTE)-1:0] bit_idx,
   output logic [BYTE_CNT_W-1:0]            byte_cnt
);

   localparam int PW = $clog2(CLKS_PER_BIT);
   localparam int RW = (MAX_RUN > 0) ? $clog2(MAX_RUN + 1) : 1;
   localparam int IW = $clog2(BITS_PER_BYTE);

   localparam logic [PW-1:0] PH_LAST  = PW'(CLKS_PER_BIT - 1);
   localparam logic [PW-1:0] PH_SAMP  = PW'(SAMPLE_PHASE);
   localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_RUN);
   localparam logic [IW-1:0] IDX_LAST = IW'(BITS_PER_BYTE - 1);
   localparam bit            STUFF    = (STUFF_EN != 0);

   logic [PW-1:0] phase;
   logic [RW-1:0] run;
   logic          sample;
   logic          is_stuff;

   // Sample strobe and stuff-bit classification for the current cycle
   always_comb begin
      sample       = rcving && (phase == PH_SAMP);
      is_stuff     = STUFF && (run == RUN_MAX);
      shift_enable = sample && !is_stuff;
      stuff_skip   = sample && is_stuff;
   end

   // Bit phase counter; a line edge re-aligns it so the edge cycle is phase 0
   always_ff @(posedge clk) begin
      if (rst || !rcving) begin
         phase <= '0;
      end else if (d_edge) begin
         phase <= PW'(1);
      end else if (phase == PH_LAST) begin
         phase <= '0;
      end else begin
         phase <= phase + PW'(1);
      end
   end

   // Run-length of sampled 1s and sticky stuffing-violation flag
   always_ff @(posedge clk) begin
      if (rst || !rcving) begin
         run       <= '0;
         stuff_err <= 1'b0;
      end else if (sample) begin
         if (is_stuff) begin
            run <= '0;
            if (d_orig) stuff_err <= 1'b1;
         end else if (!d_orig) begin
            run <= '0;
         end else if (run != RUN_MAX) begin
            // saturate so the count stays in range when stuffing is disabled
            run <= run + RW'(1);
         end
      end
   end

   // Payload bit and byte framing; byte_received is a one-cycle pulse
   always_ff @(posedge clk) begin
      if (rst || !rcving) begin
         bit_idx       <= '0;
         byte_cnt      <= '0;
         byte_received <= 1'b0;
      end else begin
         byte_received <= 1'b0;
         if (shift_enable) begin
            if (bit_idx == IDX_LAST) begin
               bit_idx       <= '0;
               byte_received <= 1'b1;
               byte_cnt      <= byte_cnt + BYTE_CNT_W'(1);
            end else begin
               bit_idx <= bit_idx + IW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_usb_rx_bit_timer.sv
// Directed bench for usb_rx_bit_timer: default instance plus a 2-bit
// byte counter instance driven by the same stimulus.
module tb_usb_rx_bit_timer;

   logic clk = 1'b0;
   logic rst, rcving, d_edge, d_orig;

   logic       se, ss, br, serr;
   logic [2:0] bidx;
   logic [7:0] bcnt;
   logic       se2, ss2, br2, serr2;
   logic [2:0] bidx2;
   logic [1:0] bcnt2;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;

   always #5 clk = ~clk;

   usb_rx_bit_timer dut (
      .clk(clk), .rst(rst), .rcving(rcving), .d_edge(d_edge), .d_orig(d_orig),
      .shift_enable(se), .stuff_skip(ss), .byte_received(br), .stuff_err(serr),
      .bit_idx(bidx), .byte_cnt(bcnt)
   );

   usb_rx_bit_timer #(.BYTE_CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .rcving(rcving), .d_edge(d_edge), .d_orig(d_orig),
      .shift_enable(se2), .stuff_skip(ss2), .byte_received(br2), .stuff_err(serr2),
      .bit_idx(bidx2), .byte_cnt(bcnt2)
   );

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got %0d want %0d", tag, cyc_n, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // ns = payload bits shifted before this cycle since rcving rose
   task automatic cmp_cycle(input int se_e, input int ss_e, input int br_e,
                            input int err_e, input int ns);
      #2;
      chk("shift_enable", int'(se), se_e);
      chk("stuff_skip", int'(ss), ss_e);
      chk("byte_received", int'(br), br_e);
      chk("stuff_err", int'(serr), err_e);
      chk("bit_idx", int'(bidx), ns % 8);
      chk("byte_cnt", int'(bcnt), (ns / 8) % 256);
      chk("byte_cnt_w2", int'(bcnt2), (ns / 8) % 4);
      chk("byte_received_w2", int'(br2), br_e);
   endtask

   // n cycles from the first rcving cycle, no edges, alternating bit values
   task automatic run_plain(input int n);
      int ns;
      ns = 0;
      for (int c = 0; c < n; c++) begin
         cyc_n  = c;
         d_edge = 1'b0;
         d_orig = ((c / 8) % 2) != 0;
         cmp_cycle((c % 8 == 2) ? 1 : 0, 0, (c >= 59 && (c - 59) % 64 == 0) ? 1 : 0, 0, ns);
         if (c % 8 == 2) ns++;
         cyc();
      end
   endtask

   task automatic restart();
      rcving = 1'b0;
      d_edge = 1'b0;
      d_orig = 1'b0;
      cyc();
      rcving = 1'b1;
   endtask

   initial begin
      int ns;
      int se_e;
      rst = 1'b1; rcving = 1'b0; d_edge = 1'b0; d_orig = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
      cyc_n = -1;
      cmp_cycle(0, 0, 0, 0, 0);

      // plain byte: shifts at 2,10,..,58, byte_received at 59
      rcving = 1'b1;
      run_plain(64);

      // edge at phase 6 re-phases the next sample to 2 cycles later
      restart();
      ns = 0;
      for (int c = 0; c <= 60; c++) begin
         cyc_n  = c;
         d_edge = (c == 6);
         d_orig = 1'b0;
         se_e   = (c == 2 || (c >= 8 && c % 8 == 0)) ? 1 : 0;
         cmp_cycle(se_e, 0, (c == 57) ? 1 : 0, 0, ns);
         ns += se_e;
         cyc();
      end

      // six 1s then a stuffed 0 at the 7th sample (cycle 50)
      restart();
      ns = 0;
      for (int c = 0; c <= 70; c++) begin
         cyc_n  = c;
         d_edge = 1'b0;
         d_orig = (c < 50);
         se_e   = (c % 8 == 2 && c != 50) ? 1 : 0;
         cmp_cycle(se_e, (c == 50) ? 1 : 0, (c == 67) ? 1 : 0, 0, ns);
         ns += se_e;
         cyc();
      end

      // seven 1s: stuff violation, sticky until rcving drops
      restart();
      ns = 0;
      for (int c = 0; c <= 60; c++) begin
         cyc_n  = c;
         d_edge = 1'b0;
         d_orig = 1'b1;
         se_e   = (c % 8 == 2 && c != 50) ? 1 : 0;
         cmp_cycle(se_e, (c == 50) ? 1 : 0, 0, (c >= 51) ? 1 : 0, ns);
         ns += se_e;
         cyc();
      end
      cyc_n  = 61;
      rcving = 1'b0;
      #2;
      chk("stuff_err_hold", int'(serr), 1);
      chk("shift_idle", int'(se), 0);
      cyc();
      cyc_n = 62;
      #2;
      chk("stuff_err_clear", int'(serr), 0);

      // rst mid-byte at bit_idx=5, then a full fresh byte
      restart();
      run_plain(36);
      cyc_n = 36;
      #2;
      chk("bit_idx_pre_rst", int'(bidx), 5);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      run_plain(100);

      // 2-bit byte counter wrap over 5 bytes, then drop on the 8th bit
      restart();
      run_plain(378);
      cyc_n  = 378;
      rcving = 1'b0;
      d_orig = 1'b0;
      #2;
      chk("shift_on_drop", int'(se), 0);
      chk("bit_idx_at_drop", int'(bidx), 7);
      chk("byte_cnt_w2_at_drop", int'(bcnt2), 1);
      cyc();
      cyc_n = 379;
      #2;
      chk("br_after_drop", int'(br), 0);
      chk("byte_cnt_after_drop", int'(bcnt), 0);
      chk("byte_cnt_w2_after_drop", int'(bcnt2), 0);
      chk("bit_idx_after_drop", int'(bidx), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/usb_rx_bit_timer.md
Name: usb_rx_bit_timer

Overview:
- Parametrised bit-timing and framing engine for the USB full-speed receive path.
- Oversamples the line at CLKS_PER_BIT clocks per bit and re-phases its sample point on every data edge (d_edge).
- Issues shift_enable to the RX shift register at a configurable sample phase and pulses byte_received every BITS_PER_BYTE payload bits.
- Recognises and suppresses stuffed bits, and flags stuffing violations to the RX control FSM.

Parameters:
- CLKS_PER_BIT, 8, clocks per bit period; must be >= 3.
- SAMPLE_PHASE, 2, phase (0..CLKS_PER_BIT-1) at which a bit is sampled.
- BITS_PER_BYTE, 8, payload bits per byte_received pulse; must be >= 2.
- STUFF_EN, 1, 1 enables bit-stuff handling; 0 makes every sample a payload bit.
- MAX_RUN, 6, consecutive sampled 1s after which the next bit is a stuff bit.
- BYTE_CNT_W, 8, width of byte_cnt.

Ports:
- clk  in  1  system clock (96 MHz nominal).
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- rcving  in  1  high while a packet is being received; low clears the framing state.
- d_edge  in  1  single-cycle pulse on a line transition.
- d_orig  in  1  decoded NRZI bit value, valid at the sample phase.
- shift_enable  out  1  combinational; high for one cycle per payload bit sampled.
- stuff_skip  out  1  combinational; high for one cycle when the sampled bit is a stuff bit.
- byte_received  out  1  registered one-cycle pulse after each completed byte.
- stuff_err  out  1  registered sticky flag: a stuff bit sampled as 1.
- bit_idx  out  $clog2(BITS_PER_BYTE)  payload bits taken in the current byte.
- byte_cnt  out  BYTE_CNT_W  bytes completed since rcving rose; wraps modulo 2^BYTE_CNT_W.

Behaviour:
- Registers: phase, run (0..MAX_RUN), bit_idx, byte_cnt, byte_received, stuff_err.
- Reset: all registers are 0, so every output is 0 in the cycle after rst is sampled high. rst overrides all other inputs, including mid-byte.
- rcving low:
  - phase, run, bit_idx, byte_cnt and byte_received are forced to 0 on the next edge.
  - stuff_err clears on the next edge.
  - shift_enable and stuff_skip are 0.
- Sample cycle: sample = rcving && (phase == SAMPLE_PHASE). The first cycle with rcving high has phase 0, so the first sample comes SAMPLE_PHASE cycles later (3rd cycle at default).
- Phase update while rcving is high:
  - d_edge high: phase_next = 1 (the edge cycle counts as phase 0).
  - Otherwise: phase_next = (phase == CLKS_PER_BIT-1) ? 0 : phase+1.
  - If d_edge and sample coincide, the sample still occurs this cycle.
- Stuff decision on a sample: is_stuff = STUFF_EN && (run == MAX_RUN).
  - shift_enable = sample && !is_stuff.
  - stuff_skip = sample && is_stuff.
- Run count on a sample:
  - is_stuff: run <= 0.
  - Otherwise: run <= d_orig ? run+1 : 0.
- stuff_err: set on a stuff sample where d_orig == 1. It stays set until rcving falls or rst.
- Payload bit counting on shift_enable:
  - If bit_idx == BITS_PER_BYTE-1: bit_idx <= 0, byte_received <= 1 for the next cycle only, byte_cnt <= byte_cnt+1.
  - Otherwise: bit_idx <= bit_idx+1.
  - Stuff bits never advance bit_idx.
- byte_received timing: it is high in the cycle after the final shift_enable and is otherwise 0.
- rcving falling on the same cycle as a final-bit shift_enable: the byte is discarded; byte_received stays 0 and the counters clear.
- byte_cnt wraps from 2^BYTE_CNT_W-1 to 0 without error.

Test Plan:
- Defaults, rst pulse, then rcving=1 with no edges and d_orig alternating 0/1 -> shift_enable in cycles 2, 10, 18, ... after rcving rises; byte_received pulses in cycle 59; byte_cnt=1; bit_idx=0.
- d_edge pulsed at phase 6 -> the next shift_enable comes 2 cycles after the edge cycle, not at the old phase-2 slot; no extra or missing bit over 8 bits.
- d_orig=1 for 6 samples, then 0 on the 7th sample -> the 7th sample gives stuff_skip=1 and shift_enable=0; bit_idx unchanged; stuff_err=0; byte_received arrives one bit period later than in the unstuffed case.
- d_orig=1 for 7 samples -> stuff_err=1 from the cycle after the 7th sample and holds; it clears one cycle after rcving drops.
- rst=1 asserted with bit_idx=5 -> all outputs 0 on the next cycle; the next byte_received requires 8 fresh bits.
- BYTE_CNT_W=2, receive 5 bytes -> byte_cnt sequence 1, 2, 3, 0, 1; rcving dropped together with the 8th shift_enable -> no byte_received, byte_cnt=0.
